// File: rtl/nios_pio_pkg.sv
// Shared constants for the NIOS II general-purpose PIO: register map and edge-type encodings.
package nios_pio_pkg;

    localparam logic [2:0] ADDR_DATA   = 3'd0;
    localparam logic [2:0] ADDR_DIR    = 3'd1;
    localparam logic [2:0] ADDR_MASK   = 3'd2;
    localparam logic [2:0] ADDR_EDGE   = 3'd3;
    localparam logic [2:0] ADDR_OUTSET = 3'd4;
    localparam logic [2:0] ADDR_OUTCLR = 3'd5;

    localparam int EDGE_RISE = 0;
    localparam int EDGE_FALL = 1;
    localparam int EDGE_ANY  = 2;

endpackage

// File: rtl/nios_pio_gen_if.sv
// Avalon-MM peripheral-bus slave port of the PIO.
// Zero-wait-state bus: no waitrequest. A write is accepted on every clk edge where
// chipselect is high and write_n is low; readdata follows address combinationally.
interface nios_pio_gen_if;

    logic [2:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;

    modport master (
        output address,
        output chipselect,
        output write_n,
        output writedata,
        input  readdata
    );

    modport slave (
        input  address,
        input  chipselect,
        input  write_n,
        input  writedata,
        output readdata
    );

endinterface

// File: rtl/nios_pio_sync.sv
// Per-bit input synchroniser chain for asynchronous pad inputs; clears to 0 on reset.
module nios_pio_sync #(
    parameter int WIDTH       = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    logic [SYNC_STAGES-1:0][WIDTH-1:0] stage;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stage <= '0;
        end else begin
            stage <= {stage[SYNC_STAGES-2:0], din};
        end
    end

    assign dout = stage[SYNC_STAGES-1];

endmodule

// File: rtl/nios_pio_gen.sv
// Parametrised Avalon-MM general-purpose PIO: direction, synchronised inputs, edge capture, masked irq.
// Define PIO_BITSET_EN to map atomic OUTSET (addr 4) and OUTCLR (addr 5) write registers.
module nios_pio_gen
    import nios_pio_pkg::*;
#(
    parameter int          WIDTH       = 8,
    parameter logic [31:0] RESET_VALUE = 32'd0,
    parameter int          EDGE_TYPE   = 0,
    parameter int          SYNC_STAGES = 2
) (
    input  logic                clk,
    input  logic                reset_n,
    nios_pio_gen_if.slave       avs,
    input  logic [WIDTH-1:0]    in_port,
    output logic [WIDTH-1:0]    out_port,
    output logic [WIDTH-1:0]    out_oe,
    output logic                irq
);

    localparam int ARM_MAX = SYNC_STAGES + 1;
    localparam int ARM_W   = $clog2(ARM_MAX + 1);

    logic             wr;
    logic [WIDTH-1:0] wd;
    logic [WIDTH-1:0] data_out;
    logic [WIDTH-1:0] dir;
    logic [WIDTH-1:0] mask;
    logic [WIDTH-1:0] edge_cap;
    logic [WIDTH-1:0] in_sync;
    logic [WIDTH-1:0] in_prev;
    logic [WIDTH-1:0] rise;
    logic [WIDTH-1:0] fall;
    logic [WIDTH-1:0] edge_sel;
    logic [WIDTH-1:0] new_edges;
    logic [ARM_W-1:0] arm_cnt;
    logic             armed;
    logic [31:0]      rd_word;

    assign wr = avs.chipselect & ~avs.write_n;
    assign wd = avs.writedata[WIDTH-1:0];

    generate
        if (WIDTH < 32) begin : g_wd_upper
            logic unused_wd_upper;
            assign unused_wd_upper = ^avs.writedata[31:WIDTH];
        end
    endgenerate

    nios_pio_sync #(
        .WIDTH       (WIDTH),
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync (
        .clk     (clk),
        .reset_n (reset_n),
        .din     (in_port),
        .dout    (in_sync)
    );

    // The arm counter hides the settling of the sync chain after reset, so a pad
    // held high through reset never looks like a rising edge.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            in_prev <= '0;
            arm_cnt <= '0;
        end else begin
            in_prev <= in_sync;
            if (!armed) begin
                arm_cnt <= arm_cnt + 1'b1;
            end
        end
    end

    assign armed = (arm_cnt == ARM_W'(ARM_MAX));
    assign rise  = in_sync & ~in_prev;
    assign fall  = ~in_sync & in_prev;

    always_comb begin
        edge_sel = rise;
        case (EDGE_TYPE)
            EDGE_FALL: edge_sel = fall;
            EDGE_ANY:  edge_sel = rise | fall;
            default:   edge_sel = rise;
        endcase
    end

    assign new_edges = armed ? edge_sel : '0;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            data_out <= RESET_VALUE[WIDTH-1:0];
            dir      <= '0;
            mask     <= '0;
        end else if (wr) begin
            case (avs.address)
                ADDR_DATA:   data_out <= wd;
                ADDR_DIR:    dir      <= wd;
                ADDR_MASK:   mask     <= wd;
`ifdef PIO_BITSET_EN
                ADDR_OUTSET: data_out <= data_out | wd;
                ADDR_OUTCLR: data_out <= data_out & ~wd;
`endif
                default: ;
            endcase
        end
    end

    // Newly detected edges are OR-ed in after the clear so an edge arriving in the
    // same cycle as its acknowledge is never lost.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            edge_cap <= '0;
            irq      <= 1'b0;
        end else begin
            if (wr && (avs.address == ADDR_EDGE)) begin
                edge_cap <= (edge_cap & ~wd) | new_edges;
            end else begin
                edge_cap <= edge_cap | new_edges;
            end
            irq <= |(edge_cap & mask);
        end
    end

    always_comb begin
        rd_word = '0;
        case (avs.address)
            ADDR_DATA: rd_word[WIDTH-1:0] = (dir & data_out) | (~dir & in_sync);
            ADDR_DIR:  rd_word[WIDTH-1:0] = dir;
            ADDR_MASK: rd_word[WIDTH-1:0] = mask;
            ADDR_EDGE: rd_word[WIDTH-1:0] = edge_cap;
            default:   rd_word = '0;
        endcase
    end

    assign avs.readdata = rd_word;
    assign out_port     = data_out;
    assign out_oe       = dir;

endmodule
